// File: rtl/rd_scoreboard.sv
// Decode-stage RAW hazard scoreboard: tracks destination registers still in flight
// and stalls decode when a source operand is not yet written back.
module rd_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int CW   = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic            issue_wr,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic            use_rs1,
  input  logic            use_rs2,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic            flush,
  output logic            stall,
  output logic            issue_accept,
  output logic [NREG-1:0] pending,
  output logic [AW:0]     inflight,
  output logic [CW-1:0]   stall_cycles
);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [NREG-1:0] wb_mask;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] eff;
  logic [NREG-1:0] pending_nxt;
  logic [AW:0]     inflight_nxt;
  logic            rs1_busy;
  logic            rs2_busy;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    wb_mask = '0;
    if (wb_valid) wb_mask[wb_rd] = 1'b1;
    // Write-through register file: a same-cycle writeback already satisfies the read.
    eff = pending & ~wb_mask;

    rs1_busy     = use_rs1 && (rs1 != '0) && eff[rs1];
    rs2_busy     = use_rs2 && (rs2 != '0) && eff[rs2];
    stall        = issue_valid && !flush && (rs1_busy || rs2_busy);
    issue_accept = issue_valid && !stall && !flush;

    set_mask = '0;
    if (issue_accept && issue_wr && (issue_rd != '0)) set_mask[issue_rd] = 1'b1;

    // Set is OR-ed after the clear, so a new write to the retiring register stays pending.
    pending_nxt    = flush ? '0 : (eff | set_mask);
    pending_nxt[0] = 1'b0;

    inflight_nxt = '0;
    for (int i = 0; i < NREG; i++) begin
      inflight_nxt = inflight_nxt + {{AW{1'b0}}, pending_nxt[i]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending      <= '0;
      inflight     <= '0;
      stall_cycles <= '0;
    end else begin
      pending  <= pending_nxt;
      inflight <= inflight_nxt;
      if (stall && (stall_cycles != CNT_MAX)) stall_cycles <= stall_cycles + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_rd_scoreboard.sv
// Self-checking bench for rd_scoreboard: directed hazard scenarios, then random traffic
// compared against a per-register outstanding-write model.
module tb_rd_scoreboard;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk;
  logic            reset;
  logic            issue_valid, issue_wr, use_rs1, use_rs2, wb_valid, flush;
  logic [AW-1:0]   issue_rd, rs1, rs2, wb_rd;
  logic            stall, issue_accept;
  logic [NREG-1:0] pending;
  logic [AW:0]     inflight;
  logic [CW-1:0]   stall_cycles;

  int checks   = 0;
  int failures = 0;

  // Reference model: which registers have an outstanding write, and stalled-cycle tally.
  bit m_out[NREG];
  int m_cnt;

  rd_scoreboard #(.NREG(NREG), .AW(AW), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .use_rs1(use_rs1), .use_rs2(use_rs2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .stall(stall), .issue_accept(issue_accept),
    .pending(pending), .inflight(inflight), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit src_busy(input logic u, input logic [AW-1:0] r);
    // A source is blocked if its register awaits a write that is not retiring right now.
    return u && (r != 0) && m_out[r] && !(wb_valid && (wb_rd == r));
  endfunction

  function automatic bit exp_stall();
    return issue_valid && !flush && (src_busy(use_rs1, rs1) || src_busy(use_rs2, rs2));
  endfunction

  function automatic logic [NREG-1:0] exp_pending();
    logic [NREG-1:0] v;
    for (int i = 0; i < NREG; i++) v[i] = m_out[i];
    return v;
  endfunction

  function automatic int exp_count();
    int n = 0;
    for (int i = 0; i < NREG; i++) n += int'(m_out[i]);
    return n;
  endfunction

  task automatic drive(input logic v, input logic wr, input int rd,
                       input int r1, input logic u1, input int r2, input logic u2,
                       input logic wbv, input int wbr, input logic fl);
    issue_valid = v;  issue_wr = wr;  issue_rd = AW'(rd);
    rs1 = AW'(r1);    use_rs1 = u1;   rs2 = AW'(r2);  use_rs2 = u2;
    wb_valid = wbv;   wb_rd = AW'(wbr); flush = fl;
    #1;
  endtask

  // Check combinational outputs, advance one clock, update the model, check state.
  task automatic tick();
    bit es, ea;
    es = exp_stall();
    ea = issue_valid && !flush && !es;
    check("stall", stall, es);
    check("issue_accept", issue_accept, ea);
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < NREG; i++) m_out[i] = 1'b0;
      m_cnt = 0;
    end else begin
      if (es && m_cnt < CMAX) m_cnt++;
      if (flush) begin
        for (int i = 0; i < NREG; i++) m_out[i] = 1'b0;
      end else begin
        if (wb_valid && wb_rd != 0) m_out[wb_rd] = 1'b0;
        if (ea && issue_wr && issue_rd != 0) m_out[issue_rd] = 1'b1;
      end
    end
    #1;
    check("pending", pending, exp_pending());
    check("inflight", inflight, exp_count());
    check("stall_cycles", stall_cycles, m_cnt);
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) m_out[i] = 1'b0;
    m_cnt = 0;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    tick();
    reset = 1'b0;
    check("reset_pending", pending, 0);
    check("reset_inflight", inflight, 0);
    check("reset_stall_cycles", stall_cycles, 0);

    // 1: producer x5, dependent reader stalls two cycles, accepted on writeback cycle.
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);  tick();
    drive(1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    check("t1_stall_c1", stall, 1);       tick();
    drive(1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    check("t1_stall_c2", stall, 1);       tick();
    drive(1, 0, 0, 5, 1, 0, 0, 1, 5, 0);
    check("t1_stall_c3", stall, 0);
    check("t1_accept_c3", issue_accept, 1); tick();
    check("t1_pending5", pending[5], 0);
    check("t1_stall_cycles", stall_cycles, 2);

    // 2: x0 is never tracked and never stalls.
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);  tick();
    drive(1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    check("t2_stall_x0", stall, 0);       tick();
    check("t2_pending", pending, 0);
    check("t2_inflight", inflight, 0);

    // 3: set and clear of x7 in the same cycle: set wins.
    drive(1, 1, 7, 0, 0, 0, 0, 1, 7, 0);  tick();
    check("t3_pending7", pending[7], 1);
    check("t3_inflight", inflight, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);  tick();

    // 4: flush with a hazarding reader present.
    drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);  tick();
    drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 0);  tick();
    drive(1, 1, 9, 0, 0, 0, 0, 0, 0, 0);  tick();
    check("t4_inflight3", inflight, 3);
    drive(1, 1, 12, 3, 1, 0, 0, 0, 0, 1);
    check("t4_flush_stall", stall, 0);
    check("t4_flush_accept", issue_accept, 0); tick();
    check("t4_pending", pending, 0);
    check("t4_inflight", inflight, 0);

    // 5: long stall saturates the counter.
    drive(1, 1, 6, 0, 0, 0, 0, 0, 0, 0);  tick();
    drive(1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
    for (int i = 0; i < 300; i++) tick();
    check("t5_saturated", stall_cycles, CMAX);
    tick();
    check("t5_held", stall_cycles, CMAX);

    // 6: reset mid-run with pending=0x230 and an active stall.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  tick();
    drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 0);  tick();
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);  tick();
    drive(1, 1, 9, 0, 0, 0, 0, 0, 0, 0);  tick();
    drive(1, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    check("t6_pending_pre", pending, 32'h0000_0230);
    check("t6_stall_pre", stall, 1);
    reset = 1'b1;                         tick();
    reset = 1'b0;
    check("t6_pending", pending, 0);
    check("t6_inflight", inflight, 0);
    check("t6_stall_cycles", stall_cycles, 0);
    check("t6_stall", stall, 0);

    // Random traffic over a small register window so hazards are frequent.
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 149) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 1) == 1,
            $urandom_range(0, 7), $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) != 0, $urandom_range(0, 7),
            $urandom_range(0, 24) == 0);
      tick();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
